// File: rtl/sha256_round_ctrl.sv
// Iterative SHA-256 compression sequencer: one round per accepted W_t, 64 rounds per block.
// Define SHA256_FINAL_ADD_EN to add the latched init_hash into hash_out in FINAL (feed-forward).
`timescale 1ns/1ps
module sha256_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] init_hash,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  output logic [5:0]   round_idx,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_FINAL = 2'd2} state_t;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t       state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic [31:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0]  a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
  logic [255:0] hash_q, hash_d;
  logic         busy_q, busy_d, w_ready_q, w_ready_d, done_q, done_d;
  logic [31:0]  t1, t2;
`ifdef SHA256_FINAL_ADD_EN
  logic [255:0] hin_q, hin_d;
`endif

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
    hash_d  = hash_q;
    done_d  = 1'b0;
`ifdef SHA256_FINAL_ADD_EN
    hin_d   = hin_q;
`endif
    t1 = h_q + big_sigma1(e_q) + ((e_q & f_q) ^ (~e_q & g_q)) + K_TAB[t_q] + w_data;
    t2 = big_sigma0(a_q) + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = init_hash;
`ifdef SHA256_FINAL_ADD_EN
          hin_d = init_hash;
`endif
          t_d     = 6'd0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (w_valid && w_ready_q) begin
          h_d = g_q; g_d = f_q; f_d = e_q; e_d = d_q + t1;
          d_d = c_q; c_d = b_q; b_d = a_q; a_d = t1 + t2;
          // round_idx parks at 63 through FINAL
          if (t_q == 6'd63) state_d = S_FINAL;
          else              t_d = t_q + 6'd1;
        end
      end
      S_FINAL: begin
`ifdef SHA256_FINAL_ADD_EN
        hash_d = {a_q + hin_q[255:224], b_q + hin_q[223:192], c_q + hin_q[191:160], d_q + hin_q[159:128],
                  e_q + hin_q[127:96],  f_q + hin_q[95:64],   g_q + hin_q[63:32],   h_q + hin_q[31:0]};
`else
        hash_d = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
`endif
        done_d  = 1'b1;
        t_d     = 6'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake/status flags are decoded from the next state so they come straight from flops
    busy_d    = (state_d != S_IDLE);
    w_ready_d = (state_d == S_ROUND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      t_q       <= 6'd0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
      hash_q    <= '0;
      busy_q    <= 1'b0;
      w_ready_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef SHA256_FINAL_ADD_EN
      hin_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
      hash_q    <= hash_d;
      busy_q    <= busy_d;
      w_ready_q <= w_ready_d;
      done_q    <= done_d;
`ifdef SHA256_FINAL_ADD_EN
      hin_q     <= hin_d;
`endif
    end
  end

  assign w_ready   = w_ready_q;
  assign round_idx = t_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hash_out  = hash_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: "abc" and the 2-block "abcdbcde..." message.
`timescale 1ns/1ps
module tb_sha256_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [255:0] init_hash = '0;
  logic         w_valid = 1'b0;
  logic [31:0]  w_data = '0;
  logic         w_ready;
  logic [5:0]   round_idx;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] DIG_ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] DIG_2BLK = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                       32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] ALT_INIT = {8{32'hdeadbeef}};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] sched [64];

  sha256_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .init_hash (init_hash),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done),
    .hash_out  (hash_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic expand(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) sched[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      sched[i] = (rotr(sched[i-2], 17) ^ rotr(sched[i-2], 19) ^ (sched[i-2] >> 10)) + sched[i-7]
               + (rotr(sched[i-15], 7) ^ rotr(sched[i-15], 18) ^ (sched[i-15] >> 3)) + sched[i-16];
  endtask

  // Reference compression over the current schedule; returns a..h without feed-forward
  function automatic logic [255:0] ref_compress(input logic [255:0] h);
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    {a, b, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + sched[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a, b, c, d, e, f, g, hh};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] sub8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] - y[32*i +: 32];
    return r;
  endfunction

  // Expected hash_out for a block started from h whose full digest is dig
  function automatic logic [255:0] exp_out(input logic [255:0] h, input logic [255:0] dig);
`ifdef SHA256_FINAL_ADD_EN
    return dig;
`else
    return sub8(dig, h);
`endif
  endfunction

  // Entered at #1 after an edge with the DUT in IDLE; returns at #1 after the done edge
  task automatic run_block(input logic [255:0] ih, input bit stall3, input int poke_t,
                           input bit do_hold, input logic [255:0] hold_val,
                           output int cyc, output int stalls);
    int  k;
    bit  vld;
    start = 1'b1; init_hash = ih;
    tick();
    start = 1'b0; init_hash = ~ih;
    chk("busy_after_start", 256'(busy), 256'(1));
    chk("done_after_start", 256'(done), 256'(0));
    k = 0; cyc = 0; stalls = 0;
    while (k < 64 && cyc < 400) begin
      vld = stall3 ? ((cyc % 3) != 2) : 1'b1;
      w_valid = vld;
      w_data  = sched[k];
      chk("round_idx", 256'(round_idx), 256'(k));
      chk("w_ready_round", 256'(w_ready), 256'(1));
      if (k == poke_t && vld) begin
        start = 1'b1; init_hash = ALT_INIT;
      end
      if (do_hold && k == 32 && vld) chk("hash_hold", hash_out, hold_val);
      tick();
      cyc++;
      start = 1'b0; init_hash = ~ih;
      if (vld) k++;
      else     stalls++;
    end
    w_valid = 1'b0;
    chk("final_busy", 256'(busy), 256'(1));
    chk("final_w_ready", 256'(w_ready), 256'(0));
    chk("final_round_idx", 256'(round_idx), 256'(63));
    chk("final_done", 256'(done), 256'(0));
    tick();
    cyc++;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("done_pulse", 256'(done), 256'(1));
    chk("done_busy", 256'(busy), 256'(0));
    chk("done_round_idx", 256'(round_idx), 256'(0));
  endtask

  initial begin
    int cyc, stalls;
    logic [255:0] h1, exp_abc, first_out;

    #1 rst_n = 1'b0;
    #3;
    chk("rst_w_ready", 256'(w_ready), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_round_idx", 256'(round_idx), 256'(0));
    chk("rst_hash_out", hash_out, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    expand(BLK1);
    h1 = add8(IV, ref_compress(IV));
    exp_abc = exp_out(IV, DIG_ABC);

    // Plain "abc"
    expand(BLK_ABC);
    run_block(IV, 1'b0, -1, 1'b0, '0, cyc, stalls);
    chk("abc_latency", 256'(cyc), 256'(65));
    chk("abc_hash", hash_out, exp_abc);
`ifndef SHA256_FINAL_ADD_EN
    chk("abc_raw_word0", 256'(hash_out[255:224]), 256'(32'h506e3058));
`endif
    tick();
    chk("done_one_cycle", 256'(done), 256'(0));
    chk("hash_held_idle", hash_out, exp_abc);

    // w_valid low every third cycle
    run_block(IV, 1'b1, -1, 1'b0, '0, cyc, stalls);
    chk("stall_latency", 256'(cyc), 256'(65 + stalls));
    chk("stall_hash", hash_out, exp_abc);
    tick();

    // start while busy must be ignored
    run_block(IV, 1'b0, 20, 1'b0, '0, cyc, stalls);
    chk("poke_latency", 256'(cyc), 256'(65));
    chk("poke_hash", hash_out, exp_abc);
    tick();

    // Async reset mid-block
    start = 1'b1; init_hash = IV;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      w_valid = 1'b1; w_data = sched[k];
      tick();
    end
    chk("abort_round_idx", 256'(round_idx), 256'(40));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_w_ready", 256'(w_ready), 256'(0));
    chk("abort_round_idx0", 256'(round_idx), 256'(0));
    chk("abort_hash_out", hash_out, 256'(0));
    chk("abort_done", 256'(done), 256'(0));
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_abort_done", 256'(done), 256'(0));
      chk("post_abort_busy", 256'(busy), 256'(0));
      chk("post_abort_w_ready", 256'(w_ready), 256'(0));
    end
    w_valid = 1'b0;
    run_block(IV, 1'b0, -1, 1'b0, '0, cyc, stalls);
    chk("rerun_latency", 256'(cyc), 256'(65));
    chk("rerun_hash", hash_out, exp_abc);
    tick();

    // Two-block message, second start issued in the done cycle
    expand(BLK1);
    run_block(IV, 1'b0, -1, 1'b0, '0, cyc, stalls);
    first_out = exp_out(IV, h1);
    chk("blk1_hash", hash_out, first_out);
    expand(BLK2);
    run_block(h1, 1'b0, -1, 1'b1, first_out, cyc, stalls);
    chk("blk2_latency", 256'(cyc), 256'(65));
    chk("blk2_hash", hash_out, exp_out(h1, DIG_2BLK));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Iterative SHA-256 compression sequencer.
- Loads an initial hash state and runs the 64 compression rounds, one per accepted message word.
- Computes Ch, Maj, Σ0 and Σ1 internally, applies the internal K_t constant table, and keeps the a..h working registers.
- Message words W_t arrive from the message-schedule block over a valid/ready handshake.
- Sits between the message scheduler and the top-level hash/digest register.

## Interface
Parameters:
- none; the round count is fixed at 64 and K_0..K_63 are an internal constant table.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a block; sampled only in IDLE.
- init_hash  in  256  H0..H7 words; [255:224] = H0 (a), [31:0] = H7 (h); sampled on the start edge.
- w_valid  in  1  w_data holds W_t for the current round.
- w_data  in  32  message word W_t.
- w_ready  out  1  high only in ROUND; a word is consumed on an edge where w_valid && w_ready.
- round_idx  out  6  index t of the word expected next, 0..63.
- busy  out  1  high in ROUND and FINAL.
- done  out  1  one-cycle pulse; hash_out is valid while it is high.
- hash_out  out  256  result register; same word order as init_hash; holds its value until the next done.

## Operation
- States:
  - IDLE: start=1 → LOAD a..h from init_hash, clear t, go to ROUND.
  - ROUND: each handshake performs one round at index t, then t ← t+1. The handshake at t=63 goes to FINAL.
  - FINAL: updates hash_out and pulses done, then goes to IDLE.
- Round arithmetic, all additions mod 2^32 with carries discarded:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K_t + W_t
  - T2 = Σ0(a) + Maj(a,b,c)
  - Ch(x,y,z) = (x&y)^(~x&z)
  - Maj = (a&b)^(a&c)^(b&c)
  - Σ0 = ROTR2^ROTR13^ROTR22
  - Σ1 = ROTR6^ROTR11^ROTR25
  - Register update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
- init_hash is latched internally at start, so the source may change during the block.
- No handshake in a ROUND cycle (w_valid=0): a..h and t hold.
- start while busy: ignored, with no effect on state.
- start in the done cycle: accepted, because the FSM is already in IDLE.
- w_valid outside ROUND: ignored; w_ready is 0.
- rst_n low at any time, including mid-block: immediately returns to IDLE and clears all registers; the partial block is discarded with no done.
- round_idx stays at 63 during FINAL and resets to 0 in IDLE.

## Timing
- Reset values: w_ready=0, busy=0, done=0, round_idx=0, hash_out=0, a..h=0, state IDLE.
- Edge E0: start accepted.
- Cycles after E0: busy=1, w_ready=1, round_idx=0.
- With no stalls, rounds occur at edges E1..E64 and FINAL is entered after E64.
- Edge E65: hash_out updated; done=1 and busy=0 for the cycle after E65.
- Latency: start to done = 65 cycles plus one cycle per stalled ROUND cycle.
- Throughput: one block per 66 cycles when start is re-asserted in the done cycle.
- All outputs are registered; there is no combinational path from w_valid to w_ready.

## Configuration
- SHA256_FINAL_ADD_EN defined: FINAL sets hash_out = latched init_hash + a..h, word-wise mod 2^32. This is the standard Davies–Meyer feed-forward.
- Not defined: FINAL sets hash_out = raw a..h, and the enclosing digest logic performs the addition. Timing is unchanged.

## Test plan
- Block "abc" (padded 616263 80 00.. len 0x18):
  - Stimulus: init_hash = standard IV 6a09e667..5be0cd19; feed the 64 scheduled W_t with w_valid held high.
  - With SHA256_FINAL_ADD_EN: hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with done exactly 65 cycles after start.
- Same block without the macro: hash_out[255:224] = 506e3058, i.e. ba7816bf − 6a09e667 mod 2^32, and the remaining words equal digest minus IV word-wise.
- "abc" with w_valid low on every third cycle:
  - identical hash_out;
  - done delayed by exactly the number of stalled ROUND cycles;
  - round_idx holds during stalls.
- start pulsed at round_idx=20 with a different init_hash: ignored, and the "abc" digest is unchanged.
- rst_n pulsed low at round_idx=40:
  - all outputs return to reset values immediately and no done is produced;
  - a fresh "abc" run afterwards yields the correct digest.
- Back-to-back operation: start asserted in the done cycle with a second block, e.g. the 2-block "abcdbcde…" message chained from the first digest. The second digest matches the reference value and hash_out holds the first digest until the second done.
